// File: rtl/decode_sequencer.sv
// decode_sequencer: fetch-to-rename decode stage controller.
//
// Fetched instruction bundles are buffered in a Q_DEPTH-entry FIFO. The head
// entry is decoded combinationally by one decode_riscv instance and offered
// to rename through out_valid/out_ready. Serializing uops are sequenced as
// DRAIN (wait for empty ROB) -> SER_ISSUE (issue alone) -> SER_WAIT (wait for
// it to retire). A must_restart uop parks the sequencer in HALT until flush.
//
// Ports:
//   clk, reset_n             clock, asynchronous active-low reset
//   mode64                   RV64 decode enable, forwarded to the decoder
//   flush                    synchronous pipeline flush, beats everything
//   rob_empty                ROB holds no uops this cycle
//   in_valid/in_ready        fetch bundle handshake
//   in_insn, in_pc, in_pred, in_pht_idx, in_pred_target   fetch bundle payload
//   out_valid/out_ready      rename handshake
//   uop_out                  decoded head uop (meaningful only when out_valid)
//   q_count                  FIFO occupancy
//   ser_stall_cnt            saturating count of DRAIN/SER_WAIT cycles

package decode_sequencer_pkg;
    localparam int M_WIDTH   = 64;
    localparam int LG_PHT_SZ = 10;

    typedef enum logic [3:0] {
        OP_ALU, OP_ALU_IMM, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
        OP_LOAD, OP_STORE, OP_FENCE, OP_CSR, OP_MONITOR, OP_ILLEGAL
    } uop_op_e;

    typedef struct packed {
        uop_op_e                op;
        logic [4:0]             rd;
        logic [4:0]             rs1;
        logic [4:0]             rs2;
        logic                   rd_valid;
        logic [31:0]            imm;
        logic [M_WIDTH-1:0]     pc;
        logic                   pred;
        logic [LG_PHT_SZ-1:0]   pht_idx;
        logic [M_WIDTH-1:0]     pred_target;
        logic                   is_word;
        logic                   serializing_op;
        logic                   must_restart;
    } uop_t;
endpackage

// decode_riscv: combinational RISC-V instruction to uop translation.
//   insn, pc, pred, pht_idx, pred_target   raw bundle fields
//   mode64                                  enables the *W (32-bit word) forms
//   uop                                     decoded uop
module decode_riscv
    import decode_sequencer_pkg::*;
(
    input  logic [31:0]          insn,
    input  logic [M_WIDTH-1:0]   pc,
    input  logic                 pred,
    input  logic [LG_PHT_SZ-1:0] pht_idx,
    input  logic [M_WIDTH-1:0]   pred_target,
    input  logic                 mode64,
    output uop_t                 uop
);
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [31:0] imm_i;

    assign opcode = insn[6:0];
    assign funct3 = insn[14:12];
    assign imm_i  = {{20{insn[31]}}, insn[31:20]};

    // Anything not recognised falls through as OP_ILLEGAL, which must trap,
    // so it is treated as serializing and restarting like SYSTEM traps.
    always_comb begin
        uop             = '0;
        uop.op          = OP_ILLEGAL;
        uop.rd          = insn[11:7];
        uop.rs1         = insn[19:15];
        uop.rs2         = insn[24:20];
        uop.pc          = pc;
        uop.pred        = pred;
        uop.pht_idx     = pht_idx;
        uop.pred_target = pred_target;
        case (opcode)
            7'h13: begin uop.op = OP_ALU_IMM; uop.rd_valid = 1'b1; uop.imm = imm_i; end
            7'h1b: if (mode64) begin
                       uop.op = OP_ALU_IMM; uop.rd_valid = 1'b1; uop.imm = imm_i; uop.is_word = 1'b1;
                   end
            7'h33: begin uop.op = OP_ALU; uop.rd_valid = 1'b1; end
            7'h3b: if (mode64) begin uop.op = OP_ALU; uop.rd_valid = 1'b1; uop.is_word = 1'b1; end
            7'h37: begin uop.op = OP_LUI; uop.rd_valid = 1'b1; uop.imm = {insn[31:12], 12'h000}; end
            7'h17: begin uop.op = OP_AUIPC; uop.rd_valid = 1'b1; uop.imm = {insn[31:12], 12'h000}; end
            7'h6f: begin
                       uop.op = OP_JAL; uop.rd_valid = 1'b1;
                       uop.imm = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
                   end
            7'h67: begin uop.op = OP_JALR; uop.rd_valid = 1'b1; uop.imm = imm_i; end
            7'h63: begin
                       uop.op = OP_BRANCH;
                       uop.imm = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
                   end
            7'h03: begin uop.op = OP_LOAD; uop.rd_valid = 1'b1; uop.imm = imm_i; end
            7'h23: begin uop.op = OP_STORE; uop.imm = {{20{insn[31]}}, insn[31:25], insn[11:7]}; end
            7'h0f: begin
                       uop.op = OP_FENCE;
                       // FENCE.I must refetch younger instructions
                       if (funct3 == 3'b001) begin
                           uop.serializing_op = 1'b1;
                           uop.must_restart   = 1'b1;
                       end
                   end
            7'h73: begin
                       if (funct3 == 3'b000) begin
                           // ECALL/EBREAK/xRET/WFI: trap-like, pipeline restarts
                           uop.op = OP_MONITOR; uop.serializing_op = 1'b1; uop.must_restart = 1'b1;
                       end else begin
                           uop.op = OP_CSR; uop.rd_valid = 1'b1; uop.serializing_op = 1'b1;
                           uop.imm = {20'h00000, insn[31:20]};
                       end
                   end
            default: ;
        endcase
        if (uop.op == OP_ILLEGAL) begin
            uop.serializing_op = 1'b1;
            uop.must_restart   = 1'b1;
        end
        uop.rd_valid = uop.rd_valid & (insn[11:7] != 5'd0);
    end
endmodule

module decode_sequencer
    import decode_sequencer_pkg::*;
#(
    parameter int Q_DEPTH = 4,
    parameter int LG_Q    = 2
)(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 mode64,
    input  logic                 flush,
    input  logic                 rob_empty,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_insn,
    input  logic [M_WIDTH-1:0]   in_pc,
    input  logic                 in_pred,
    input  logic [LG_PHT_SZ-1:0] in_pht_idx,
    input  logic [M_WIDTH-1:0]   in_pred_target,
    output logic                 out_valid,
    input  logic                 out_ready,
    output uop_t                 uop_out,
    output logic [LG_Q:0]        q_count,
    output logic [31:0]          ser_stall_cnt
);
    typedef enum logic [2:0] {RUN, DRAIN, SER_ISSUE, SER_WAIT, HALT} state_e;

    state_e state;

    logic [LG_Q:0] rd_ptr;
    logic [LG_Q:0] wr_ptr;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    logic [31:0]          q_insn        [Q_DEPTH];
    logic [M_WIDTH-1:0]   q_pc          [Q_DEPTH];
    logic                 q_pred        [Q_DEPTH];
    logic [LG_PHT_SZ-1:0] q_pht_idx     [Q_DEPTH];
    logic [M_WIDTH-1:0]   q_pred_target [Q_DEPTH];

    // Pointers carry an extra wrap bit: equal means empty, differing only in
    // the wrap bit means full.
    assign full    = (rd_ptr ^ wr_ptr) == {1'b1, {LG_Q{1'b0}}};
    assign empty   = (rd_ptr == wr_ptr);
    assign q_count = wr_ptr - rd_ptr;

    // Ready is held low throughout reset and during a flush cycle so nothing
    // is accepted that the flush would immediately throw away.
    assign in_ready = reset_n & ~full & ~flush;
    assign push     = in_valid & in_ready;
    assign pop      = out_valid & out_ready;

    decode_riscv u_decode (
        .insn        (q_insn[rd_ptr[LG_Q-1:0]]),
        .pc          (q_pc[rd_ptr[LG_Q-1:0]]),
        .pred        (q_pred[rd_ptr[LG_Q-1:0]]),
        .pht_idx     (q_pht_idx[rd_ptr[LG_Q-1:0]]),
        .pred_target (q_pred_target[rd_ptr[LG_Q-1:0]]),
        .mode64      (mode64),
        .uop         (uop_out)
    );

    // Issue is a pure decode of registered state and FIFO contents. In RUN a
    // serializing head is never offered; it waits for DRAIN to finish.
    always_comb begin
        out_valid = 1'b0;
        if (!flush) begin
            case (state)
                RUN:       out_valid = ~empty & ~uop_out.serializing_op;
                SER_ISSUE: out_valid = ~empty;
                default:   out_valid = 1'b0;
            endcase
        end
    end

    // Payload storage is not reset; the pointers alone define what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            q_insn[wr_ptr[LG_Q-1:0]]        <= in_insn;
            q_pc[wr_ptr[LG_Q-1:0]]          <= in_pc;
            q_pred[wr_ptr[LG_Q-1:0]]        <= in_pred;
            q_pht_idx[wr_ptr[LG_Q-1:0]]     <= in_pht_idx;
            q_pred_target[wr_ptr[LG_Q-1:0]] <= in_pred_target;
        end
    end

    // Pointers, sequencing FSM and stall counter. The stall counter keeps
    // counting through a flush because only reset clears it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            state         <= RUN;
            ser_stall_cnt <= '0;
        end else begin
            if ((state == DRAIN || state == SER_WAIT) && ser_stall_cnt != 32'hFFFF_FFFF)
                ser_stall_cnt <= ser_stall_cnt + 32'd1;
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                state  <= RUN;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                case (state)
                    RUN:       if (!empty && uop_out.serializing_op) state <= DRAIN;
                    DRAIN:     if (rob_empty) state <= SER_ISSUE;
                    SER_ISSUE: if (pop) state <= uop_out.must_restart ? HALT : SER_WAIT;
                    SER_WAIT:  if (rob_empty) state <= RUN;
                    HALT:      ;
                    default:   state <= RUN;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_decode_sequencer.sv
// tb_decode_sequencer: directed bench for decode_sequencer.
// Inputs change just after each falling edge and outputs are sampled 1ns
// later, so every commit happens on the rising edge between two steps.
module tb_decode_sequencer;
    import decode_sequencer_pkg::*;

    localparam logic [31:0] ADDI    = 32'h00100093;
    localparam logic [31:0] RDCYCLE = 32'hc00022f3;
    localparam logic [31:0] MONITOR = 32'h00100073;

    logic                 clk;
    logic                 reset_n;
    logic                 mode64;
    logic                 flush;
    logic                 rob_empty;
    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          in_insn;
    logic [M_WIDTH-1:0]   in_pc;
    logic                 in_pred;
    logic [LG_PHT_SZ-1:0] in_pht_idx;
    logic [M_WIDTH-1:0]   in_pred_target;
    logic                 out_valid;
    logic                 out_ready;
    uop_t                 uop_out;
    logic [2:0]           q_count;
    logic [31:0]          ser_stall_cnt;

    int checks   = 0;
    int passed   = 0;
    int failures = 0;

    decode_sequencer #(.Q_DEPTH(4), .LG_Q(2)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .mode64         (mode64),
        .flush          (flush),
        .rob_empty      (rob_empty),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_insn        (in_insn),
        .in_pc          (in_pc),
        .in_pred        (in_pred),
        .in_pht_idx     (in_pht_idx),
        .in_pred_target (in_pred_target),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .uop_out        (uop_out),
        .q_count        (q_count),
        .ser_stall_cnt  (ser_stall_cnt)
    );

    // Free-running 10ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to the next falling edge, drive one step, settle 1ns
    task automatic applyStimulus(input logic v, input logic [31:0] insn, input logic [63:0] pc,
                                 input logic ordy, input logic robe, input logic fl);
        @(negedge clk);
        in_valid       = v;
        in_insn        = insn;
        in_pc          = pc;
        in_pht_idx     = pc[11:2];
        in_pred_target = pc + 64'h40;
        out_ready      = ordy;
        rob_empty      = robe;
        flush          = fl;
        #1;
    endtask

    // One comparison; observed against bench-computed expectation
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Directed sequence covering streaming, full FIFO, serialization,
    // restart/HALT, flush and asynchronous reset.
    initial begin
        reset_n = 1'b0; mode64 = 1'b1; flush = 1'b0; rob_empty = 1'b1;
        in_valid = 1'b0; in_insn = '0; in_pc = '0; in_pred = 1'b0;
        in_pht_idx = '0; in_pred_target = '0; out_ready = 1'b0;
        #2;
        checkOutput("rst_in_ready",  64'(in_ready), 64'd0);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_q_count",   64'(q_count), 64'd0);
        checkOutput("rst_stall_cnt", 64'(ser_stall_cnt), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // 1: stream 8 ADDI with rename always ready
        $display("[TB] streaming ADDI");
        for (int k = 0; k <= 8; k++) begin
            applyStimulus(k < 8, ADDI, 64'h1000 + 64'(4 * k), 1'b1, 1'b1, 1'b0);
            checkOutput("t1_out_valid", 64'(out_valid), 64'(k > 0));
            checkOutput("t1_q_count", 64'(q_count), 64'(k > 0));
            if (k > 0)
                checkOutput("t1_pc", uop_out.pc, 64'h1000 + 64'(4 * (k - 1)));
            if (k == 1) begin
                checkOutput("t1_op", 64'(uop_out.op), 64'(OP_ALU_IMM));
                checkOutput("t1_imm", 64'(uop_out.imm), 64'd1);
                checkOutput("t1_rd", 64'(uop_out.rd), 64'd1);
                checkOutput("t1_target", uop_out.pred_target, 64'h1040);
            end
        end
        applyStimulus(1'b0, ADDI, 64'h0, 1'b1, 1'b1, 1'b0);
        checkOutput("t1_drained_valid", 64'(out_valid), 64'd0);
        checkOutput("t1_drained_count", 64'(q_count), 64'd0);

        // 2: fill to full with rename stalled, then release
        $display("[TB] fill and release");
        for (int j = 0; j < 5; j++) begin
            applyStimulus(1'b1, ADDI, 64'h2000 + 64'(4 * j), 1'b0, 1'b1, 1'b0);
            checkOutput("t2_q_count", 64'(q_count), 64'(j));
            checkOutput("t2_in_ready", 64'(in_ready), 64'(j < 4));
        end
        for (int m = 0; m < 5; m++) begin
            applyStimulus(1'b0, ADDI, 64'h0, 1'b1, 1'b1, 1'b0);
            checkOutput("t2_out_valid", 64'(out_valid), 64'(m < 4));
            checkOutput("t2_q_count_rel", 64'(q_count), 64'(4 - m));
            if (m < 4)
                checkOutput("t2_pc", uop_out.pc, 64'h2000 + 64'(4 * m));
        end

        // 3: ADDI, RDCYCLE, ADDI with ROB busy
        $display("[TB] serializing RDCYCLE");
        applyStimulus(1'b1, ADDI, 64'h3000, 1'b1, 1'b0, 1'b0);
        checkOutput("t3_first_idle", 64'(out_valid), 64'd0);
        applyStimulus(1'b1, RDCYCLE, 64'h3004, 1'b1, 1'b0, 1'b0);
        checkOutput("t3_addi_valid", 64'(out_valid), 64'd1);
        checkOutput("t3_addi_pc", uop_out.pc, 64'h3000);
        applyStimulus(1'b1, ADDI, 64'h3008, 1'b1, 1'b0, 1'b0);
        checkOutput("t3_ser_head_blocked", 64'(out_valid), 64'd0);
        checkOutput("t3_q_count_a", 64'(q_count), 64'd1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, ADDI, 64'h0, 1'b1, 1'b0, 1'b0);
            checkOutput("t3_drain_valid", 64'(out_valid), 64'd0);
            checkOutput("t3_drain_count", 64'(q_count), 64'd2);
        end
        applyStimulus(1'b0, ADDI, 64'h0, 1'b1, 1'b1, 1'b0);
        checkOutput("t3_drain_last", 64'(out_valid), 64'd0);
        checkOutput("t3_stall_5", 64'(ser_stall_cnt), 64'd5);
        applyStimulus(1'b0, ADDI, 64'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("t3_ser_valid", 64'(out_valid), 64'd1);
        checkOutput("t3_ser_pc", uop_out.pc, 64'h3004);
        checkOutput("t3_ser_op", 64'(uop_out.op), 64'(OP_CSR));
        checkOutput("t3_ser_restart", 64'(uop_out.must_restart), 64'd0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, ADDI, 64'h0, 1'b1, 1'b0, 1'b0);
            checkOutput("t3_wait_valid", 64'(out_valid), 64'd0);
            checkOutput("t3_wait_count", 64'(q_count), 64'd1);
        end
        applyStimulus(1'b0, ADDI, 64'h0, 1'b1, 1'b1, 1'b0);
        checkOutput("t3_wait_last", 64'(out_valid), 64'd0);
        applyStimulus(1'b0, ADDI, 64'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("t3_trail_valid", 64'(out_valid), 64'd1);
        checkOutput("t3_trail_pc", uop_out.pc, 64'h3008);
        checkOutput("t3_stall_9", 64'(ser_stall_cnt), 64'd9);
        applyStimulus(1'b0, ADDI, 64'h0, 1'b1, 1'b1, 1'b0);
        checkOutput("t3_empty", 64'(q_count), 64'd0);

        // 4: MONITOR restarts -> HALT until flush
        $display("[TB] must_restart and HALT");
        applyStimulus(1'b1, MONITOR, 64'h4000, 1'b1, 1'b1, 1'b0);
        checkOutput("t4_idle", 64'(out_valid), 64'd0);
        applyStimulus(1'b1, ADDI, 64'h4004, 1'b1, 1'b1, 1'b0);
        checkOutput("t4_run_blocked", 64'(out_valid), 64'd0);
        applyStimulus(1'b0, ADDI, 64'h0, 1'b1, 1'b1, 1'b0);
        checkOutput("t4_drain", 64'(out_valid), 64'd0);
        applyStimulus(1'b0, ADDI, 64'h0, 1'b1, 1'b1, 1'b0);
        checkOutput("t4_mon_valid", 64'(out_valid), 64'd1);
        checkOutput("t4_mon_pc", uop_out.pc, 64'h4000);
        checkOutput("t4_mon_restart", 64'(uop_out.must_restart), 64'd1);
        checkOutput("t4_mon_op", 64'(uop_out.op), 64'(OP_MONITOR));
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, ADDI, 64'h0, 1'b1, 1'b1, 1'b0);
            checkOutput("t4_halt_valid", 64'(out_valid), 64'd0);
            checkOutput("t4_halt_count", 64'(q_count), 64'd1);
        end
        applyStimulus(1'b1, ADDI, 64'h4008, 1'b1, 1'b1, 1'b1);
        checkOutput("t4_flush_valid", 64'(out_valid), 64'd0);
        checkOutput("t4_flush_ready", 64'(in_ready), 64'd0);
        applyStimulus(1'b1, ADDI, 64'h4100, 1'b1, 1'b1, 1'b0);
        checkOutput("t4_post_count", 64'(q_count), 64'd0);
        checkOutput("t4_post_valid", 64'(out_valid), 64'd0);
        checkOutput("t4_post_ready", 64'(in_ready), 64'd1);
        applyStimulus(1'b0, ADDI, 64'h0, 1'b1, 1'b1, 1'b0);
        checkOutput("t4_run_valid", 64'(out_valid), 64'd1);
        checkOutput("t4_run_pc", uop_out.pc, 64'h4100);
        checkOutput("t4_stall_10", 64'(ser_stall_cnt), 64'd10);

        // 5: flush with three queued while push and pop are requested
        $display("[TB] flush with queued entries");
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, ADDI, 64'h5000 + 64'(4 * i), 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, ADDI, 64'h500c, 1'b1, 1'b1, 1'b1);
        checkOutput("t5_pre_count", 64'(q_count), 64'd3);
        checkOutput("t5_flush_valid", 64'(out_valid), 64'd0);
        checkOutput("t5_flush_ready", 64'(in_ready), 64'd0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, ADDI, 64'h0, 1'b1, 1'b1, 1'b0);
            checkOutput("t5_post_count", 64'(q_count), 64'd0);
            checkOutput("t5_post_valid", 64'(out_valid), 64'd0);
        end

        // 6: asynchronous reset while in DRAIN
        $display("[TB] reset mid-DRAIN");
        applyStimulus(1'b1, RDCYCLE, 64'h6000, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, ADDI, 64'h6004, 1'b1, 1'b0, 1'b0);
        checkOutput("t6_blocked", 64'(out_valid), 64'd0);
        applyStimulus(1'b0, ADDI, 64'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("t6_drain_count", 64'(q_count), 64'd2);
        checkOutput("t6_drain_stall", 64'(ser_stall_cnt), 64'd10);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("t6_rst_count", 64'(q_count), 64'd0);
        checkOutput("t6_rst_valid", 64'(out_valid), 64'd0);
        checkOutput("t6_rst_ready", 64'(in_ready), 64'd0);
        checkOutput("t6_rst_stall", 64'(ser_stall_cnt), 64'd0);
        applyStimulus(1'b0, ADDI, 64'h0, 1'b1, 1'b1, 1'b0);
        checkOutput("t6_held_count", 64'(q_count), 64'd0);
        reset_n = 1'b1;
        applyStimulus(1'b1, ADDI, 64'h6100, 1'b1, 1'b1, 1'b0);
        checkOutput("t6_resume_idle", 64'(out_valid), 64'd0);
        applyStimulus(1'b0, ADDI, 64'h0, 1'b1, 1'b1, 1'b0);
        checkOutput("t6_resume_valid", 64'(out_valid), 64'd1);
        checkOutput("t6_resume_pc", uop_out.pc, 64'h6100);
        checkOutput("t6_resume_stall", 64'(ser_stall_cnt), 64'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
